// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// datapath mux selects and branch funct3 codes.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StJalr,
        StLui,
        StIllegal
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [1:0] AluOpAdd   = 2'd0;
    localparam logic [1:0] AluOpSub   = 2'd1;
    localparam logic [1:0] AluOpFunct = 2'd2;

    localparam logic [1:0] ResAluOut    = 2'd0;
    localparam logic [1:0] ResData      = 2'd1;
    localparam logic [1:0] ResAluResult = 2'd2;

    localparam logic [2:0] ImmI = 3'd0;
    localparam logic [2:0] ImmS = 3'd1;
    localparam logic [2:0] ImmB = 3'd2;
    localparam logic [2:0] ImmJ = 3'd3;
    localparam logic [2:0] ImmU = 3'd4;

    localparam logic [1:0] SrcAPc    = 2'd0;
    localparam logic [1:0] SrcAOldPc = 2'd1;
    localparam logic [1:0] SrcARd1   = 2'd2;

    localparam logic [1:0] SrcBRd2  = 2'd0;
    localparam logic [1:0] SrcBImm  = 2'd1;
    localparam logic [1:0] SrcBFour = 2'd2;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle. master = controller, slave = datapath.
interface multicycle_controller_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [3:0] Flags;
    logic       mem_ready;

    logic       mem_req;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ResultSrc;
    logic [2:0] ImmSrc;
    logic       illegal_instr;

    modport master (
        input  opcode, funct3, funct7_5, Flags, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, illegal_instr
    );

    modport slave (
        output opcode, funct3, funct7_5, Flags, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, illegal_instr
    );

endinterface

// File: rtl/multicycle_controller_branch_cond.sv
// Branch decision from funct3 and ALU flags {N,Z,C,V} of rs1-rs2.
// C=1 means no borrow, so unsigned less-than is !C.
module branch_cond
    import mc_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [3:0] flags,
    output logic       take,
    output logic       illegal
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        take    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3Beq:   take = z;
            F3Bne:   take = ~z;
            F3Blt:   take = n ^ v;
            F3Bge:   take = ~(n ^ v);
            F3Bltu:  take = ~c;
            F3Bgeu:  take = c;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I instruction sequencer, one FSM state per cycle.
// Optional performance counters are built when MC_PERF_COUNTERS_EN is defined.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter logic RESET_PC_WRITE = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [31:0]             cycle_cnt,
    output logic [31:0]             instret_cnt
`endif
);

    state_e state_q, state_d;
    logic   jalr_second_q, jalr_second_d;
    logic   br_take, br_illegal;
    logic   unused_funct7_5;

    // funct7 decoding is done by the ALU decoder when ALUOp selects funct
    assign unused_funct7_5 = bus.funct7_5;

    branch_cond u_branch_cond (
        .funct3  (bus.funct3),
        .flags   (bus.Flags),
        .take    (br_take),
        .illegal (br_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StFetch;
            jalr_second_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            jalr_second_q <= jalr_second_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        jalr_second_d     = 1'b0;
        bus.mem_req       = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.AdrSrc        = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.PCWrite       = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.ALUSrcA       = SrcAPc;
        bus.ALUSrcB       = SrcBRd2;
        bus.ALUOp         = AluOpAdd;
        bus.ResultSrc     = ResAluOut;
        bus.ImmSrc        = ImmI;
        bus.illegal_instr = 1'b0;

        case (state_q)
            StFetch: begin
                bus.mem_req   = 1'b1;
                bus.ALUSrcB   = SrcBFour;
                bus.ResultSrc = ResAluResult;
                if (bus.mem_ready) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    state_d     = StDecode;
                end
            end
            StDecode: begin
                bus.ALUSrcA = SrcAOldPc;
                bus.ALUSrcB = SrcBImm;
                bus.ImmSrc  = ImmB;
                case (bus.opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecR;
                    OpItype:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpLui:           state_d = StLui;
                    default:         state_d = StIllegal;
                endcase
            end
            StMemAdr: begin
                bus.ALUSrcA = SrcARd1;
                bus.ALUSrcB = SrcBImm;
                if (bus.opcode == OpLoad) begin
                    bus.ImmSrc = ImmI;
                    state_d    = StMemRead;
                end else begin
                    bus.ImmSrc = ImmS;
                    state_d    = StMemWrite;
                end
            end
            StMemRead: begin
                bus.mem_req = 1'b1;
                bus.AdrSrc  = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                bus.ResultSrc = ResData;
                bus.RegWrite  = 1'b1;
                state_d       = StFetch;
            end
            StMemWrite: begin
                bus.mem_req  = 1'b1;
                bus.MemWrite = 1'b1;
                bus.AdrSrc   = 1'b1;
                if (bus.mem_ready) state_d = StFetch;
            end
            StExecR: begin
                bus.ALUSrcA = SrcARd1;
                bus.ALUSrcB = SrcBRd2;
                bus.ALUOp   = AluOpFunct;
                state_d     = StAluWb;
            end
            StExecI: begin
                bus.ALUSrcA = SrcARd1;
                bus.ALUSrcB = SrcBImm;
                bus.ALUOp   = AluOpFunct;
                bus.ImmSrc  = ImmI;
                state_d     = StAluWb;
            end
            StAluWb: begin
                bus.RegWrite = 1'b1;
                state_d      = StFetch;
            end
            StBranch: begin
                bus.ALUSrcA       = SrcARd1;
                bus.ALUSrcB       = SrcBRd2;
                bus.ALUOp         = AluOpSub;
                bus.PCWrite       = br_take & ~br_illegal;
                bus.illegal_instr = br_illegal;
                state_d           = StFetch;
            end
            StJal: begin
                bus.ALUSrcA  = SrcAOldPc;
                bus.ALUSrcB  = SrcBFour;
                bus.PCWrite  = 1'b1;
                bus.RegWrite = 1'b1;
                bus.ImmSrc   = ImmJ;
                state_d      = StFetch;
            end
            StJalr: begin
                // First cycle forms rs1+imm into ALUOut; second commits PC and rd
                if (!jalr_second_q) begin
                    bus.ALUSrcA   = SrcARd1;
                    bus.ALUSrcB   = SrcBImm;
                    bus.ImmSrc    = ImmI;
                    jalr_second_d = 1'b1;
                end else begin
                    bus.ALUSrcA  = SrcAOldPc;
                    bus.ALUSrcB  = SrcBFour;
                    bus.PCWrite  = 1'b1;
                    bus.RegWrite = 1'b1;
                    state_d      = StFetch;
                end
            end
            StLui: begin
                bus.ALUSrcA = SrcARd1;
                bus.ALUSrcB = SrcBImm;
                bus.ImmSrc  = ImmU;
                state_d     = StAluWb;
            end
            StIllegal: begin
                bus.illegal_instr = 1'b1;
                state_d           = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Reset may land mid-handshake; keep every strobe and select quiet
        if (reset) begin
            bus.mem_req       = 1'b0;
            bus.MemWrite      = 1'b0;
            bus.AdrSrc        = 1'b0;
            bus.IRWrite       = 1'b0;
            bus.PCWrite       = RESET_PC_WRITE;
            bus.RegWrite      = 1'b0;
            bus.ALUSrcA       = SrcAPc;
            bus.ALUSrcB       = SrcBRd2;
            bus.ALUOp         = AluOpAdd;
            bus.ResultSrc     = ResAluOut;
            bus.ImmSrc        = ImmI;
            bus.illegal_instr = 1'b0;
        end
    end

`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cycle_cnt_q, instret_cnt_q;
    logic        retire;

    assign retire = (state_d == StFetch) && (state_q != StFetch) && (state_q != StIllegal);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (retire) instret_cnt_q <= instret_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule
